// File: rtl/spi_frame_sequencer.sv
// SPI command sequencer: config register file, burst pixel capture, and the pixel
// coordinator that follows either the SPI burst stream or the camera stream.
module spi_frame_sequencer #(
  parameter int ImageW = 640,
  parameter int ImageH = 480,
  parameter int NReg   = 8
) (
  input  logic              clk_p,
  input  logic              rst_p,
  input  logic              css,
  input  logic              byte_rdy,
  input  logic [7:0]        byte_i,
  output logic [7:0]        resp_o,
  input  logic [8:0]        ret_data,
  input  logic              cam_dv,
  input  logic              cam_rst,
  output logic              pix_en,
  output logic              pix_rst,
  output logic [23:0]       pixA,
  output logic [23:0]       pixB,
  output logic [10:0]       pix_x,
  output logic [10:0]       pix_y,
  output logic              frame_done,
  output logic [8*NReg-1:0] cfg_o,
  output logic              src_spi
);

  localparam int AW = $clog2(NReg);

  typedef enum logic [2:0] {
    IDLE, OPC, ADDR_R, ADDR_W, DATA_W, BURST, DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    regs_q [NReg];
  logic [7:0]    regs_d [NReg];
  logic [AW-1:0] addr_q, addr_d;
  logic          scr_rst_q, scr_rst_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [39:0]   grp_q, grp_d;
  logic [7:0]    resp_q, resp_d;
  logic [23:0]   pixa_q, pixa_d;
  logic [23:0]   pixb_q, pixb_d;
  logic          spi_pix_q, spi_pix_d;
  logic [10:0]   x_q, x_d;
  logic [10:0]   y_q, y_d;
  logic          done_q, done_d;
  logic [7:0]    ret_sat;

  // A 9-bit signed value never exceeds 255, so only the negative side clamps.
  assign ret_sat = ret_data[8] ? 8'h00 : ret_data[7:0];

  assign src_spi = (regs_q[2] != 8'h00);
  assign pix_en  = src_spi ? spi_pix_q : cam_dv;
  assign pix_rst = src_spi ? scr_rst_q : cam_rst;

  assign resp_o     = resp_q;
  assign pixA       = pixa_q;
  assign pixB       = pixb_q;
  assign pix_x      = x_q;
  assign pix_y      = y_q;
  assign frame_done = done_q;

  always_comb begin
    cfg_o = '0;
    for (int k = 0; k < NReg; k++) cfg_o[8*k +: 8] = regs_q[k];
  end

  always_comb begin
    state_d   = state_q;
    regs_d    = regs_q;
    addr_d    = addr_q;
    scr_rst_d = scr_rst_q;
    cnt_d     = cnt_q;
    grp_d     = grp_q;
    resp_d    = resp_q;
    pixa_d    = pixa_q;
    pixb_d    = pixb_q;
    spi_pix_d = 1'b0;
    x_d       = x_q;
    y_d       = y_q;
    done_d    = 1'b0;

    // Dropping css abandons whatever was in flight, including a partial pixel group.
    if (!css) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
      resp_d  = 8'hFF;
    end else begin
      unique case (state_q)
        IDLE: state_d = OPC;
        OPC: if (byte_rdy) begin
          case (byte_i)
            8'h81:   state_d = ADDR_R;
            8'h80:   state_d = ADDR_W;
            8'h55:   state_d = BURST;
            8'h40: begin scr_rst_d = 1'b0; state_d = DRAIN; end
            8'h41: begin scr_rst_d = 1'b1; state_d = DRAIN; end
            default: state_d = DRAIN;
          endcase
        end
        ADDR_R: if (byte_rdy) begin
          resp_d  = regs_q[byte_i[AW-1:0]];
          state_d = DRAIN;
        end
        ADDR_W: if (byte_rdy) begin
          addr_d  = byte_i[AW-1:0];
          state_d = DATA_W;
        end
        DATA_W: if (byte_rdy) begin
          regs_d[addr_q] = byte_i;
          state_d        = DRAIN;
        end
        BURST: if (byte_rdy) begin
          resp_d = ret_sat;
          if (cnt_q == 3'd5) begin
            pixa_d    = grp_q[39:16];
            pixb_d    = {grp_q[15:0], byte_i};
            cnt_d     = 3'd0;
            spi_pix_d = 1'b1;
          end else begin
            grp_d = {grp_q[31:0], byte_i};
            cnt_d = cnt_q + 3'd1;
          end
        end
        DRAIN:   state_d = DRAIN;
        default: state_d = IDLE;
      endcase
    end

    // Frame reset wins over a coincident pixel strobe.
    if (pix_rst) begin
      x_d = 11'd0;
      y_d = 11'd0;
    end else if (pix_en) begin
      if (x_q == 11'(ImageW - 1)) begin
        x_d = 11'd0;
        if (y_q == 11'(ImageH - 1)) begin
          y_d    = 11'd0;
          done_d = 1'b1;
        end else begin
          y_d = y_q + 11'd1;
        end
      end else begin
        x_d = x_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk_p or posedge rst_p) begin
    if (rst_p) begin
      state_q <= IDLE;
      for (int k = 0; k < NReg; k++) regs_q[k] <= 8'h00;
      addr_q    <= '0;
      scr_rst_q <= 1'b0;
      cnt_q     <= 3'd0;
      grp_q     <= 40'd0;
      resp_q    <= 8'hFF;
      pixa_q    <= 24'd0;
      pixb_q    <= 24'd0;
      spi_pix_q <= 1'b0;
      x_q       <= 11'd0;
      y_q       <= 11'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      regs_q    <= regs_d;
      addr_q    <= addr_d;
      scr_rst_q <= scr_rst_d;
      cnt_q     <= cnt_d;
      grp_q     <= grp_d;
      resp_q    <= resp_d;
      pixa_q    <= pixa_d;
      pixb_q    <= pixb_d;
      spi_pix_q <= spi_pix_d;
      x_q       <= x_d;
      y_q       <= y_d;
      done_q    <= done_d;
    end
  end

endmodule
